// File: rtl/acc_loader_pkg.sv
// Shared constants, enums and helpers for the accelerator operand loader.
// Optional build macro: ACC_LOADER_CHECKSUM_EN (adds CHECK state / trailer byte).
package acc_loader_pkg;

    localparam int unsigned DEF_NUM_IN = 64;
    localparam int unsigned DEF_NUM_W  = 96;
    localparam int unsigned DEF_NUM_BN = 6;
    localparam int unsigned CNT_W      = 7;

    localparam logic [7:0] HDR_IN    = 8'hA0;
    localparam logic [7:0] HDR_W     = 8'hA1;
    localparam logic [7:0] HDR_BN    = 8'hA2;
    localparam logic [7:0] HDR_START = 8'hA3;

    typedef enum logic [1:0] {
        BANK_IN = 2'd0,
        BANK_W  = 2'd1,
        BANK_BN = 2'd2
    } bank_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK,
        START_WAIT
    } state_e;

    function automatic logic [CNT_W-1:0] bank_len(input bank_e b, input int unsigned n_in,
                                                   input int unsigned n_w, input int unsigned n_bn);
        logic [CNT_W-1:0] len;
        case (b)
            BANK_IN: len = CNT_W'(n_in);
            BANK_W:  len = CNT_W'(n_w);
            default: len = CNT_W'(n_bn);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/acc_operand_loader_if.sv
// Byte-stream valid/ready channel feeding the operand loader.
// Optional build macro: ACC_LOADER_CHECKSUM_EN (no effect on this interface).
interface acc_operand_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/acc_loader_bank.sv
// Byte-addressed register bank with write enable and synchronous clear.
// Optional build macro: ACC_LOADER_CHECKSUM_EN (no effect on this module).
module acc_loader_bank
    import acc_loader_pkg::*;
#(
    parameter int unsigned LEN    = 8,
    parameter int unsigned ADDR_W = CNT_W
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_data,
    output logic [LEN*8-1:0]  o_bus
);

    logic [LEN-1:0][7:0] r_bytes;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_bytes <= '0;
        end else if (i_we) begin
            for (int unsigned k = 0; k < LEN; k++) begin
                if (i_addr == ADDR_W'(k)) r_bytes[k] <= i_data;
            end
        end
    end

    assign o_bus = r_bytes;

endmodule

// File: rtl/acc_operand_loader.sv
// Decodes bank-tagged byte packets into input/weight/BN banks and issues the array start pulse.
// Optional build macro: ACC_LOADER_CHECKSUM_EN (trailer byte = payload sum mod 256, checked in CHECK).
module acc_operand_loader
    import acc_loader_pkg::*;
#(
    parameter int unsigned NUM_IN = DEF_NUM_IN,
    parameter int unsigned NUM_W  = DEF_NUM_W,
    parameter int unsigned NUM_BN = DEF_NUM_BN
) (
    input  logic                  clk,
    input  logic                  reset_n,
    acc_operand_loader_if.slave   rx,
    input  logic                  sa_busy,
    output logic [NUM_IN*8-1:0]   in_bus,
    output logic [NUM_W*8-1:0]    w_bus,
    output logic [NUM_BN*8-1:0]   bn_bus,
    output logic [2:0]            loaded,
    output logic                  sa_start,
    output logic                  err
);

    state_e           r_state;
    state_e           w_next;
    bank_e            r_bank;
    bank_e            w_hdr_bank;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_len;
    logic [2:0]       r_loaded;
    logic             r_err;
    logic             r_start;
    logic             r_rx_ready;
`ifdef ACC_LOADER_CHECKSUM_EN
    logic [7:0]       r_sum;
`endif

    logic w_xfer;
    logic w_last;
    logic w_open;
    logic w_wr;
    logic w_done_ok;
    logic w_done_bad;
    logic w_start_set;
    logic w_err_set;

    assign w_xfer     = rx.rx_valid && r_rx_ready;
    assign w_hdr_bank = bank_e'(rx.rx_data[1:0]);
    assign w_len      = bank_len(r_bank, NUM_IN, NUM_W, NUM_BN);
    assign w_last     = (r_cnt == w_len - CNT_W'(1));

    always_comb begin
        w_next      = r_state;
        w_open      = 1'b0;
        w_wr        = 1'b0;
        w_done_ok   = 1'b0;
        w_done_bad  = 1'b0;
        w_start_set = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    if (rx.rx_data == HDR_IN || rx.rx_data == HDR_W || rx.rx_data == HDR_BN) begin
                        w_open = 1'b1;
                        w_next = LOAD;
                    end else if (rx.rx_data == HDR_START) begin
                        // A start still in flight defers the new one so pulses never abut
                        if (r_loaded != 3'b111)         w_err_set   = 1'b1;
                        else if (!sa_busy && !r_start)  w_start_set = 1'b1;
                        else                            w_next      = START_WAIT;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (w_xfer) begin
                    w_wr = 1'b1;
                    if (w_last) begin
`ifdef ACC_LOADER_CHECKSUM_EN
                        w_next = CHECK;
`else
                        w_done_ok = 1'b1;
                        w_next    = IDLE;
`endif
                    end
                end
            end
            CHECK: begin
`ifdef ACC_LOADER_CHECKSUM_EN
                if (w_xfer) begin
                    if (rx.rx_data == r_sum) begin
                        w_done_ok = 1'b1;
                    end else begin
                        w_done_bad = 1'b1;
                        w_err_set  = 1'b1;
                    end
                    w_next = IDLE;
                end
`else
                w_next = IDLE;
`endif
            end
            START_WAIT: begin
                if (!sa_busy) begin
                    w_start_set = 1'b1;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_bank     <= BANK_IN;
            r_cnt      <= '0;
            r_loaded   <= '0;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
            r_rx_ready <= 1'b0;
`ifdef ACC_LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_state    <= w_next;
            r_rx_ready <= (w_next != START_WAIT);
            r_start    <= w_start_set;
            if (w_err_set) r_err <= 1'b1;
            if (w_open) begin
                r_bank             <= w_hdr_bank;
                r_cnt              <= '0;
                r_loaded[w_hdr_bank] <= 1'b0;
`ifdef ACC_LOADER_CHECKSUM_EN
                r_sum              <= '0;
`endif
            end
            if (w_wr) begin
                r_cnt <= r_cnt + CNT_W'(1);
`ifdef ACC_LOADER_CHECKSUM_EN
                r_sum <= r_sum + rx.rx_data;
`endif
            end
            if (w_done_ok)  r_loaded[r_bank] <= 1'b1;
            if (w_done_bad) r_loaded[r_bank] <= 1'b0;
        end
    end

    acc_loader_bank #(.LEN(NUM_IN), .ADDR_W(CNT_W)) u_bank_in (
        .clk    (clk),
        .i_clr  (!reset_n),
        .i_we   (w_wr && r_bank == BANK_IN),
        .i_addr (r_cnt),
        .i_data (rx.rx_data),
        .o_bus  (in_bus)
    );

    acc_loader_bank #(.LEN(NUM_W), .ADDR_W(CNT_W)) u_bank_w (
        .clk    (clk),
        .i_clr  (!reset_n),
        .i_we   (w_wr && r_bank == BANK_W),
        .i_addr (r_cnt),
        .i_data (rx.rx_data),
        .o_bus  (w_bus)
    );

    acc_loader_bank #(.LEN(NUM_BN), .ADDR_W(CNT_W)) u_bank_bn (
        .clk    (clk),
        .i_clr  (!reset_n),
        .i_we   (w_wr && r_bank == BANK_BN),
        .i_addr (r_cnt),
        .i_data (rx.rx_data),
        .o_bus  (bn_bus)
    );

    assign rx.rx_ready = r_rx_ready;
    assign loaded      = r_loaded;
    assign sa_start    = r_start;
    assign err         = r_err;

endmodule

// File: tb/tb_acc_operand_loader.sv
// Self-checking bench for acc_operand_loader: packet table plus hand-written start/reset sequences.
// Honours ACC_LOADER_CHECKSUM_EN (appends trailer bytes and runs the checksum cases).
module tb_acc_operand_loader;
    import acc_loader_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             sa_busy = 1'b0;
    logic [64*8-1:0]  in_bus;
    logic [96*8-1:0]  w_bus;
    logic [6*8-1:0]   bn_bus;
    logic [2:0]       loaded;
    logic             sa_start;
    logic             err;

    acc_operand_loader_if rx ();

    acc_operand_loader #(.NUM_IN(64), .NUM_W(96), .NUM_BN(6)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (rx),
        .sa_busy  (sa_busy),
        .in_bus   (in_bus),
        .w_bus    (w_bus),
        .bn_bus   (bn_bus),
        .loaded   (loaded),
        .sa_start (sa_start),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  hdr;
        int unsigned len;
        int          pat;      // 0: base + step*i, 1: BN pattern 01 00 02 00 03 00
        logic [7:0]  base;
        logic [7:0]  step;
        bit          bad;
        logic [2:0]  exp_loaded;
        logic        exp_err;
    } pkt_t;

    typedef struct {
        logic [1:0]  bank;
        int unsigned idx;
        logic [7:0]  val;
    } wr_t;

    pkt_t        tbl [9];
    wr_t         sbq [$];
    bit          gaps = 1'b0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        prev_start = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int pat, input logic [7:0] base,
                                       input logic [7:0] step, input int unsigned i);
        if (pat == 1) return (i % 2 == 0) ? 8'(i / 2 + 1) : 8'h00;
        return 8'(int'(base) + int'(step) * int'(i));
    endfunction

    function automatic logic [7:0] bus_byte(input logic [1:0] bank, input int unsigned idx);
        case (bank)
            2'd0:    return in_bus[idx*8 +: 8];
            2'd1:    return w_bus[idx*8 +: 8];
            default: return bn_bus[idx*8 +: 8];
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int unsigned t = 0;
        if (gaps) begin
            rx.rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rx.rx_data  = b;
        rx.rx_valid = 1'b1;
        while (!rx.rx_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (!rx.rx_ready) begin
            chk("rx_ready_timeout", 64'd0, 64'd1);
            rx.rx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        rx.rx_valid = 1'b0;
    endtask

    task automatic apply_pkt(input int unsigned n, input pkt_t p);
        logic [7:0] sum = 8'h00;
        logic [7:0] v;
        send_byte(p.hdr);
        for (int unsigned i = 0; i < p.len; i++) begin
            v = pay(p.pat, p.base, p.step, i);
            sum = sum + v;
            send_byte(v);
            sbq.push_back('{p.hdr[1:0], i, v});
        end
`ifdef ACC_LOADER_CHECKSUM_EN
        if (p.len > 0) send_byte(p.bad ? sum + 8'h01 : sum);
`endif
        while (sbq.size() > 0) begin
            wr_t w = sbq.pop_front();
            chk($sformatf("pkt%0d_byte%0d", n, w.idx), 64'(bus_byte(w.bank, w.idx)), 64'(w.val));
        end
        chk($sformatf("pkt%0d_loaded", n), 64'(loaded), 64'(p.exp_loaded));
        chk($sformatf("pkt%0d_err", n), 64'(err), 64'(p.exp_err));
    endtask

    task automatic do_reset(input bit ck);
        reset_n     = 1'b0;
        rx.rx_valid = 1'b0;
        sa_busy     = 1'b0;
        sbq.delete();
        repeat (2) begin @(posedge clk); #1; end
        if (ck) begin
            chk("rst_rx_ready", 64'(rx.rx_ready), 64'd0);
            chk("rst_loaded", 64'(loaded), 64'd0);
            chk("rst_err", 64'(err), 64'd0);
            chk("rst_sa_start", 64'(sa_start), 64'd0);
            chk("rst_in_bus", 64'(|in_bus), 64'd0);
            chk("rst_w_bus", 64'(|w_bus), 64'd0);
            chk("rst_bn_bus", 64'(|bn_bus), 64'd0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        if (ck) chk("post_rst_rx_ready", 64'(rx.rx_ready), 64'd1);
    endtask

    always @(negedge clk) begin
        if (prev_start) chk("sa_start_back2back", 64'(sa_start), 64'd0);
        prev_start = sa_start;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{HDR_IN,  64, 0, 8'h00, 8'h01, 1'b0, 3'b001, 1'b0};
        tbl[1] = '{HDR_W,   96, 0, 8'hFF, 8'h00, 1'b0, 3'b011, 1'b0};
        tbl[2] = '{HDR_BN,   6, 1, 8'h00, 8'h00, 1'b0, 3'b111, 1'b0};
        tbl[3] = '{HDR_IN,  64, 0, 8'h80, 8'h03, 1'b0, 3'b111, 1'b0};
        tbl[4] = '{8'h5C,    0, 0, 8'h00, 8'h00, 1'b0, 3'b000, 1'b1};
        tbl[5] = '{HDR_IN,  64, 0, 8'h10, 8'h07, 1'b0, 3'b001, 1'b1};
        tbl[6] = '{HDR_BN,   6, 1, 8'h00, 8'h00, 1'b0, 3'b100, 1'b0};
        tbl[7] = '{HDR_BN,   6, 1, 8'h00, 8'h00, 1'b0, 3'b100, 1'b0};
        tbl[8] = '{HDR_BN,   6, 1, 8'h00, 8'h00, 1'b1, 3'b000, 1'b1};
        rx.rx_valid = 1'b0;
        rx.rx_data  = 8'h00;

        do_reset(1'b1);
        for (int unsigned i = 0; i < 3; i++) apply_pkt(i, tbl[i]);
        chk("in_bus_byte5", 64'(in_bus[5*8 +: 8]), 64'h05);
        chk("bn_bus_lunda", 64'(bn_bus[15:0]), 64'h0001);

        // Start with array idle: pulse exactly one cycle after A3
        send_byte(HDR_START);
        chk("start_idle_pulse", 64'(sa_start), 64'd1);
        chk("start_idle_loaded", 64'(loaded), 64'b111);
        @(posedge clk); #1;
        chk("start_idle_low", 64'(sa_start), 64'd0);
        chk("start_idle_err", 64'(err), 64'd0);

        // Start held off while busy
        sa_busy = 1'b1;
        send_byte(HDR_START);
        for (int unsigned c = 0; c < 10; c++) begin
            chk($sformatf("busy_rx_ready_c%0d", c), 64'(rx.rx_ready), 64'd0);
            chk($sformatf("busy_sa_start_c%0d", c), 64'(sa_start), 64'd0);
            @(posedge clk); #1;
        end
        sa_busy = 1'b0;
        @(posedge clk); #1;
        chk("busy_release_start", 64'(sa_start), 64'd1);
        chk("busy_release_ready", 64'(rx.rx_ready), 64'd1);
        @(posedge clk); #1;
        chk("busy_release_low", 64'(sa_start), 64'd0);

        // Reload input bank with gaps; loaded stays complete, then back-to-back starts
        gaps = 1'b1;
        apply_pkt(3, tbl[3]);
        gaps = 1'b0;
        send_byte(HDR_START);
        chk("b2b_first_pulse", 64'(sa_start), 64'd1);
        send_byte(HDR_START);
        repeat (3) begin @(posedge clk); #1; end
        chk("b2b_err", 64'(err), 64'd0);

        // Start with only the input bank loaded
        do_reset(1'b0);
        apply_pkt(0, tbl[0]);
        send_byte(HDR_START);
        chk("partial_start_none", 64'(sa_start), 64'd0);
        chk("partial_err", 64'(err), 64'd1);
        chk("partial_loaded", 64'(loaded), 64'b001);
        @(posedge clk); #1;
        chk("partial_start_none2", 64'(sa_start), 64'd0);

        // Bad header, then a good packet
        do_reset(1'b0);
        gaps = 1'b1;
        apply_pkt(4, tbl[4]);
        chk("badhdr_in_bus", 64'(|in_bus), 64'd0);
        apply_pkt(5, tbl[5]);
        gaps = 1'b0;

        // Reset in the middle of a weight packet
        do_reset(1'b0);
        send_byte(HDR_W);
        for (int unsigned i = 0; i < 30; i++) send_byte(8'hFF);
        chk("midpkt_w_byte0", 64'(w_bus[7:0]), 64'hFF);
        chk("midpkt_w_byte29", 64'(w_bus[29*8 +: 8]), 64'hFF);
        chk("midpkt_w_byte30", 64'(w_bus[30*8 +: 8]), 64'h00);
        do_reset(1'b1);
        apply_pkt(6, tbl[6]);

`ifdef ACC_LOADER_CHECKSUM_EN
        do_reset(1'b0);
        apply_pkt(7, tbl[7]);
        gaps = 1'b1;
        apply_pkt(8, tbl[8]);
        gaps = 1'b0;
`endif

        repeat (3) begin @(posedge clk); #1; end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
